// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- parametrised multi-cycle ALU
//
// Sequential successor to the 8-bit combinational ALU. It keeps the same
// 16-opcode fsl map and {V,S,C,Z} status register, widened to WIDTH bits.
// Added over the combinational version:
//   - a valid/ready request/result handshake;
//   - registered result and flags;
//   - barrel shifts/rotates by B[SHW-1:0];
//   - a shift-add multiplier retiring one multiplier bit per cycle.
// Position in the datapath: between register-file read and writeback.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operation request
//   in_ready   out  1      block can accept a request (state + out_valid only)
//   A          in   WIDTH  operand 1
//   B          in   WIDTH  operand 2 / shift-rotate amount in B[SHW-1:0]
//   fsl        in   4      opcode
//   out_valid  out  1      result, mul_high and SREG are valid
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  low result (low product for MUL)
//   mul_high   out  WIDTH  high product for MUL, 0 otherwise
//   SREG       out  4      flags {V,S,C,Z}
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       fsl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] mul_high,
  output logic [3:0]       SREG
);

  // ---------------------------------------------------------------------------
  // Opcode map and FSM states
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_ADDC = 4'h2, OP_SUBC = 4'h3,
    OP_XOR  = 4'h4, OP_AND  = 4'h5, OP_OR   = 4'h6, OP_NAND = 4'h7,
    OP_LSL  = 4'h8, OP_LSR  = 4'h9, OP_ASL  = 4'hA, OP_ASR  = 4'hB,
    OP_ROL  = 4'hC, OP_ROR  = 4'hD, OP_MUL  = 4'hE, OP_CMP  = 4'hF
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Flag bit positions inside SREG
  localparam int FV = 3;
  localparam int FS = 2;
  localparam int FC = 1;
  localparam int FZ = 0;

  localparam logic [SHW:0]   W_EXT    = (SHW+1)'(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH-1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   result_reg;
  logic [WIDTH-1:0]   mul_high_reg;
  logic [3:0]         sreg_reg;

  // Multiplier working registers: multiplicand, and the running product
  // {prod_hi, prod_lo}. prod_lo starts as the multiplier and is consumed
  // from its LSB while product bits shift in from the top.
  logic [WIDTH-1:0]   mc_a_reg;
  logic [WIDTH-1:0]   prod_hi_reg;
  logic [WIDTH-1:0]   prod_lo_reg;
  logic [SHW-1:0]     cnt_reg;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath (operates on live inputs; used at the accept edge)
  // ---------------------------------------------------------------------------
  op_e                op;
  logic [SHW-1:0]     shamt;
  logic               cin;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH:0]     lsl_ext;       // {last bit out, result}
  logic [WIDTH:0]     lsr_ext;       // {result, last bit out}
  logic signed [WIDTH:0] asr_src;
  logic signed [WIDTH:0] asr_ext;    // {result, last bit out}
  logic [2*WIDTH-1:0] rol_wide;
  logic [2*WIDTH-1:0] ror_wide;
  logic [WIDTH-1:0]   asl_lost_diff;
  logic               asl_v;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;
  logic               alu_c;
  logic [3:0]         alu_flags;

  assign op    = op_e'(fsl);
  assign shamt = B[SHW-1:0];

  // Carry-in comes from the flag register as it stands at the accept edge,
  // i.e. the C of the previously completed operation.
  assign cin = ((op == OP_ADDC) || (op == OP_SUBC)) ? sreg_reg[FC] : 1'b0;

  assign sum_ext  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
  // Bit WIDTH of the zero-extended difference is the unsigned borrow.
  assign diff_ext = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, cin};

  // Widened shifts capture the last bit shifted out in the extra position;
  // for a zero amount that position holds the 0 pad, giving C = 0.
  assign lsl_ext  = {1'b0, A} << shamt;
  assign lsr_ext  = {A, 1'b0} >> shamt;
  assign asr_src  = {A, 1'b0};
  assign asr_ext  = asr_src >>> shamt;

  // Rotates via a doubled operand: upper half after a left shift, lower half
  // after a right shift. Amount 0 returns A.
  assign rol_wide = {A, A} << shamt;
  assign ror_wide = {A, A} >> shamt;

  // ASL overflow: bit gi is shifted out when gi + n >= WIDTH; any such bit
  // that differs from the original sign bit means the value changed sign.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_asl_lost
    assign asl_lost_diff[gi] =
      (((SHW+1)'(gi) + {1'b0, shamt}) >= W_EXT) && (A[gi] != A[WIDTH-1]);
  end

  assign asl_v = (|asl_lost_diff) || (lsl_ext[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    unique case (op)
      OP_ADD, OP_ADDC: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_SUBC, OP_CMP: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) &&
                  (diff_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_XOR:  alu_res = A ^ B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NAND: alu_res = ~(A & B);
      OP_LSL: begin
        alu_res = lsl_ext[WIDTH-1:0];
        alu_c   = lsl_ext[WIDTH];
      end
      OP_ASL: begin
        alu_res = lsl_ext[WIDTH-1:0];
        alu_c   = lsl_ext[WIDTH];
        alu_v   = asl_v;
      end
      OP_LSR: begin
        alu_res = lsr_ext[WIDTH:1];
        alu_c   = lsr_ext[0];
      end
      OP_ASR: begin
        alu_res = asr_ext[WIDTH:1];
        alu_c   = asr_ext[0];
      end
      OP_ROL:  alu_res = rol_wide[2*WIDTH-1:WIDTH];
      OP_ROR:  alu_res = ror_wide[WIDTH-1:0];
      OP_MUL:  alu_res = '0;   // handled by the iterative path
      default: alu_res = '0;
    endcase
  end

  assign alu_flags = {alu_v, alu_res[WIDTH-1], alu_c, ~|alu_res};

  // ---------------------------------------------------------------------------
  // Shift-add multiplier step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_next;
  logic [WIDTH-1:0]   mul_lo_next;
  logic [3:0]         mul_flags;

  assign mul_sum = {1'b0, prod_hi_reg} +
                   (prod_lo_reg[0] ? {1'b0, mc_a_reg} : {(WIDTH+1){1'b0}});
  // Shift the whole product right by one, the adder carry entering the top.
  assign {mul_hi_next, mul_lo_next} = {mul_sum, prod_lo_reg[WIDTH-1:1]};

  assign mul_flags = {|mul_hi_next, mul_hi_next[WIDTH-1], 1'b0,
                      ~|{mul_hi_next, mul_lo_next}};

  // ---------------------------------------------------------------------------
  // Control FSM and output registers
  // ---------------------------------------------------------------------------
  logic accept;

  assign in_ready = (state_reg == ST_IDLE) && !out_valid_reg;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      mul_high_reg  <= '0;
      sreg_reg      <= '0;
      mc_a_reg      <= '0;
      prod_hi_reg   <= '0;
      prod_lo_reg   <= '0;
      cnt_reg       <= '0;
    end else begin
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end

      unique case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mc_a_reg    <= A;
              prod_hi_reg <= '0;
              prod_lo_reg <= B;
              cnt_reg     <= '0;
              state_reg   <= ST_MUL;
            end else begin
              result_reg    <= alu_res;
              mul_high_reg  <= '0;
              sreg_reg      <= alu_flags;
              out_valid_reg <= 1'b1;
            end
          end
        end

        ST_MUL: begin
          prod_hi_reg <= mul_hi_next;
          prod_lo_reg <= mul_lo_next;
          cnt_reg     <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            result_reg    <= mul_lo_next;
            mul_high_reg  <= mul_hi_next;
            sreg_reg      <= mul_flags;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign mul_high  = mul_high_reg;
  assign SREG      = sreg_reg;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc -- directed self-checking bench for alu_mc (WIDTH = 8)
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_mc;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       fsl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] mul_high;
  logic [3:0]       SREG;

  int total_cnt = 0;
  int pass_cnt  = 0;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .fsl      (fsl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .mul_high (mul_high),
    .SREG     (SREG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one non-MUL op with out_ready=1, check it one cycle after accept,
  // then let it be consumed.
  task automatic run_op(input string tag, input logic [3:0] f,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input logic [3:0] exp_sreg);
    in_valid = 1'b1; fsl = f; A = a; B = b;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_sreg"}, SREG, exp_sreg);
    chk({tag, "_mul_high"}, mul_high, 0);
    $display("op %s f=%h A=%h B=%h -> result=%h SREG=%b", tag, f, a, b, result, SREG);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; fsl = '0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_sreg", SREG, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Arithmetic, carry chain and flag persistence
    run_op("add_ovf", 4'h0, 8'h7F, 8'h01, 8'h80, 4'b1100);
    chk("add_consumed", out_valid, 0);
    chk("sreg_persist", SREG, 4'b1100);
    run_op("sub_borrow", 4'h1, 8'h00, 8'h01, 8'hFF, 4'b0110);
    run_op("addc_cin", 4'h2, 8'h01, 8'h01, 8'h03, 4'b0000);
    run_op("cmp_eq", 4'hF, 8'h05, 8'h05, 8'h00, 4'b0001);

    // Logic
    run_op("xor", 4'h4, 8'hAA, 8'h55, 8'hFF, 4'b0100);
    run_op("nand_zero", 4'h7, 8'hFF, 8'hFF, 8'h00, 4'b0001);

    // Shifts and rotates
    run_op("asr3", 4'hB, 8'h80, 8'h03, 8'hF0, 4'b0100);
    run_op("lsl1", 4'h8, 8'h81, 8'h01, 8'h02, 4'b0010);
    run_op("lsl0", 4'h8, 8'h81, 8'h00, 8'h81, 4'b0100);
    run_op("lsr1", 4'h9, 8'h03, 8'h01, 8'h01, 4'b0010);
    run_op("asl_ovf", 4'hA, 8'h40, 8'h01, 8'h80, 4'b1100);
    run_op("ror1", 4'hD, 8'h01, 8'h01, 8'h80, 4'b0100);
    run_op("rol1", 4'hC, 8'h81, 8'h01, 8'h03, 4'b0000);

    // MUL 0xFF*0xFF, with a competing ADD request held during the iteration
    in_valid = 1'b1; fsl = 4'hE; A = 8'hFF; B = 8'hFF;
    tick();
    fsl = 4'h0; A = 8'h11; B = 8'h22;
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy_ov", out_valid, 0);
      chk("mul_busy_ir", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("mul_done_ov", out_valid, 1);
    chk("mul_result", result, 8'h01);
    chk("mul_high", mul_high, 8'hFE);
    chk("mul_sreg", SREG, 4'b1100);
    $display("op mul A=ff B=ff -> high=%h result=%h SREG=%b", mul_high, result, SREG);
    tick();
    chk("mul_consumed", out_valid, 0);
    tick();
    chk("no_queue", out_valid, 0);

    // Backpressure: result held, no new accept while A keeps changing
    out_ready = 1'b0;
    in_valid = 1'b1; fsl = 4'h0; A = 8'h10; B = 8'h20;
    tick();
    for (int i = 0; i < 5; i++) begin
      A = 8'(i + 1);
      tick();
      chk("bp_ov", out_valid, 1);
      chk("bp_result", result, 8'h30);
      chk("bp_ir", in_ready, 0);
    end
    $display("op backpressure add 10+20 held result=%h", result);
    out_ready = 1'b1; A = 8'h01; B = 8'h01;
    tick();
    chk("bp_consumed", out_valid, 0);
    chk("bp_ready_again", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_ov", out_valid, 1);
    chk("bp_next_result", result, 8'h02);
    $display("op add 01+01 after backpressure -> result=%h", result);
    tick();

    // Reset during MUL
    run_op("sub_pre_rst", 4'h1, 8'h00, 8'h01, 8'hFF, 4'b0110);
    in_valid = 1'b1; fsl = 4'hE; A = 8'h0F; B = 8'h0F;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", out_valid, 0);
    chk("mrst_ir", in_ready, 1);
    chk("mrst_result", result, 0);
    chk("mrst_high", mul_high, 0);
    chk("mrst_sreg", SREG, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mrst_no_ov", out_valid, 0);
    end
    $display("op mul abandoned by reset");
    run_op("add_after_rst", 4'h0, 8'h7F, 8'h01, 8'h80, 4'b1100);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
